// File: rtl/mult_div_ctrl_if.sv
// Signal bundle between the control unit, the mult/div sequencer and the Booth multiplier / divider units.
interface mult_div_ctrl_if;
    logic        start_mult;
    logic        start_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wr_data;
    logic        mult_op;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        div_op;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output start_mult, start_div, operand_a, operand_b, hi_we, lo_we, wr_data,
        output mult_hi, mult_lo, div_hi, div_lo,
        input  mult_op, mult_a, mult_b, div_op, div_a, div_b,
        input  hi_out, lo_out, busy, done, div_zero
    );

    modport slave (
        input  start_mult, start_div, operand_a, operand_b, hi_we, lo_we, wr_data,
        input  mult_hi, mult_lo, div_hi, div_lo,
        output mult_op, mult_a, mult_b, div_op, div_a, div_b,
        output hi_out, lo_out, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// Sequencer for MULT/DIV: latches operands, runs the selected unit for a fixed
// cycle count, captures HI/LO and handshakes busy/done with the control unit.
module mult_div_ctrl #(
    parameter int unsigned MULT_CYCLES = 32,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT_RUN,
        S_DIV_RUN,
        S_CAPTURE,
        S_DONE
    } state_e;

    localparam int unsigned DW = 32;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sel_div_q, sel_div_d;
    logic              zero_q, zero_d;
    logic [DW-1:0]     mult_a_q, mult_a_d, mult_b_q, mult_b_d;
    logic [DW-1:0]     div_a_q, div_a_d, div_b_q, div_b_d;
    logic [DW-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic              mult_op_q, mult_op_d, div_op_q, div_op_d;
    logic              busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sel_div_q  <= 1'b0;
            zero_q     <= 1'b0;
            mult_a_q   <= '0;
            mult_b_q   <= '0;
            div_a_q    <= '0;
            div_b_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mult_op_q  <= 1'b0;
            div_op_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_div_q  <= sel_div_d;
            zero_q     <= zero_d;
            mult_a_q   <= mult_a_d;
            mult_b_q   <= mult_b_d;
            div_a_q    <= div_a_d;
            div_b_q    <= div_b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mult_op_q  <= mult_op_d;
            div_op_q   <= div_op_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Next-state, operand latching and HI/LO update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_div_d = sel_div_q;
        zero_d    = zero_q;
        mult_a_d  = mult_a_q;
        mult_b_d  = mult_b_q;
        div_a_d   = div_a_q;
        div_b_d   = div_b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.hi_we) hi_d = bus.wr_data;
                if (bus.lo_we) lo_d = bus.wr_data;
                if (bus.start_mult) begin
                    mult_a_d  = bus.operand_a;
                    mult_b_d  = bus.operand_b;
                    cnt_d     = '0;
                    sel_div_d = 1'b0;
                    zero_d    = 1'b0;
                    state_d   = S_MULT_RUN;
                end else if (bus.start_div) begin
                    div_a_d   = bus.operand_a;
                    div_b_d   = bus.operand_b;
                    cnt_d     = '0;
                    sel_div_d = 1'b1;
                    zero_d    = (bus.operand_b == '0);
                    state_d   = (bus.operand_b == '0) ? S_DONE : S_DIV_RUN;
                end
            end
            S_MULT_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MULT_CYCLES - 1)) state_d = S_CAPTURE;
            end
            S_DIV_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIV_CYCLES - 1)) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                hi_d    = sel_div_q ? bus.div_hi : bus.mult_hi;
                lo_d    = sel_div_q ? bus.div_lo : bus.mult_lo;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the upcoming state so they line up with it
        mult_op_d  = (state_d == S_MULT_RUN) || ((state_d == S_CAPTURE) && !sel_div_d);
        div_op_d   = (state_d == S_DIV_RUN)  || ((state_d == S_CAPTURE) &&  sel_div_d);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        div_zero_d = (state_d == S_DONE) && zero_d;
    end

    assign bus.mult_op  = mult_op_q;
    assign bus.mult_a   = mult_a_q;
    assign bus.mult_b   = mult_b_q;
    assign bus.div_op   = div_op_q;
    assign bus.div_a    = div_a_q;
    assign bus.div_b    = div_b_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;

endmodule
